// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write scoreboard; x0 reads as zero.
// Define WB_BYPASS_EN to forward write-back data and mask the matching stall term.
module regfile_scoreboard #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  input  logic              RS1_used,
  input  logic              RS2_used,
  output logic [WIDTH-1:0]  RS1_data,
  output logic [WIDTH-1:0]  RS2_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] RD,
  input  logic [WIDTH-1:0]  RD_data,
  output logic              hazard_stall,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam logic [ADDR_W:0] CntOne = (ADDR_W+1)'(1);

  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wb_v, iss_v, inc, dec;
  logic              stall1, stall2;

  assign wb_v  = wb_en && (RD != '0);
  assign iss_v = issue_en && (issue_rd != '0);

  // Set wins over clear when issue and write-back target the same register.
  always_comb begin
    busy_d = busy_q;
    if (wb_v)  busy_d[RD]       = 1'b0;
    if (iss_v) busy_d[issue_rd] = 1'b1;
  end

  always_comb begin
    inc   = iss_v && !busy_q[issue_rd];
    dec   = wb_v && busy_q[RD] && !(iss_v && (issue_rd == RD));
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CntOne;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (wb_v) regs_q[RD] <= RD_data;
    end
  end

  always_comb begin
    RS1_data = (RS1 == '0) ? '0 : regs_q[RS1];
    RS2_data = (RS2 == '0) ? '0 : regs_q[RS2];
    stall1   = RS1_used && busy_q[RS1];
    stall2   = RS2_used && busy_q[RS2];
`ifdef WB_BYPASS_EN
    // A same-cycle issue to RD names a newer producer, so that stall must hold.
    if (wb_v && (RS1 == RD)) begin
      RS1_data = RD_data;
      if (!(issue_en && (issue_rd == RD))) stall1 = 1'b0;
    end
    if (wb_v && (RS2 == RD)) begin
      RS2_data = RD_data;
      if (!(issue_en && (issue_rd == RD))) stall2 = 1'b0;
    end
`endif
  end

  assign hazard_stall = stall1 || stall2;
  assign pend_cnt     = cnt_q;

endmodule
